// File: rtl/w5300_init_seq_if.sv
// Request/acknowledge host bus toward the W5300 parallel interface.
interface w5300_init_seq_if;
    logic        bus_req;
    logic        bus_we;
    logic [9:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/w5300_init_seq.sv
// W5300 power-up sequencer: settle, soft reset, poll MR, program the network
// identity registers, read SIPR back and report done / error.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_SETTLE | waiting SETTLE_CYCLES after reset release
// S_SRST   | writing MR = 0x0080 (soft reset)
// S_POLL   | reading MR until bit 7 clears or POLL_LIMIT reads elapse
// S_CFG    | writing SHAR, GAR, SUBR, SIPR (nine words)
// S_VERIFY | reading SIPR hi/lo back and comparing
// S_DONE   | sequence finished and verified; start re-runs it
// S_ERR    | poll timeout or readback mismatch; start re-runs it
module w5300_init_seq #(
    parameter logic [47:0] MAC           = 48'h00_08_DC_01_02_03,
    parameter logic [31:0] GW_IP         = 32'hC0A8_0001,
    parameter logic [31:0] SUBNET        = 32'hFFFF_FF00,
    parameter logic [31:0] SRC_IP        = 32'hC0A8_0064,
    parameter int          SETTLE_CYCLES = 500000,
    parameter int          POLL_LIMIT    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    w5300_init_seq_if.master    bus,
    output logic                busy,
    output logic                done,
    output logic                err_n
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int POLL_W   = $clog2(POLL_LIMIT + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [POLL_W-1:0]   POLL_LAST   = POLL_W'(POLL_LIMIT);
    localparam logic [3:0]          CFG_LAST    = 4'd8;

    typedef enum logic [2:0] {
        S_SETTLE,
        S_SRST,
        S_POLL,
        S_CFG,
        S_VERIFY,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [POLL_W-1:0]   poll_cnt;
    logic [3:0]          cfg_idx;
    logic                vfy_idx;

    logic                nxt_we;
    logic [9:0]          nxt_addr;
    logic [15:0]         nxt_wdata;
    logic [15:0]         vfy_exp;
    logic [POLL_W-1:0]   poll_inc;
    logic                xfer_state;
    logic                acked;

    // Next transfer description, derived from the state and its word index.
    always_comb begin
        nxt_we    = 1'b0;
        nxt_addr  = 10'h000;
        nxt_wdata = 16'h0000;
        case (state)
            S_SRST: begin
                nxt_we    = 1'b1;
                nxt_wdata = 16'h0080;
            end
            S_CFG: begin
                nxt_we = 1'b1;
                case (cfg_idx)
                    4'd0:    begin nxt_addr = 10'h008; nxt_wdata = MAC[47:32];    end
                    4'd1:    begin nxt_addr = 10'h00A; nxt_wdata = MAC[31:16];    end
                    4'd2:    begin nxt_addr = 10'h00C; nxt_wdata = MAC[15:0];     end
                    4'd3:    begin nxt_addr = 10'h010; nxt_wdata = GW_IP[31:16];  end
                    4'd4:    begin nxt_addr = 10'h012; nxt_wdata = GW_IP[15:0];   end
                    4'd5:    begin nxt_addr = 10'h014; nxt_wdata = SUBNET[31:16]; end
                    4'd6:    begin nxt_addr = 10'h016; nxt_wdata = SUBNET[15:0];  end
                    4'd7:    begin nxt_addr = 10'h018; nxt_wdata = SRC_IP[31:16]; end
                    default: begin nxt_addr = 10'h01A; nxt_wdata = SRC_IP[15:0];  end
                endcase
            end
            S_VERIFY: nxt_addr = vfy_idx ? 10'h01A : 10'h018;
            default: ;
        endcase
    end

    // Handshake helpers and readback expectation.
    always_comb begin
        vfy_exp    = vfy_idx ? SRC_IP[15:0] : SRC_IP[31:16];
        poll_inc   = poll_cnt + 1'b1;
        xfer_state = (state == S_SRST) || (state == S_POLL) ||
                     (state == S_CFG)  || (state == S_VERIFY);
        // An ack with no outstanding request is ignored.
        acked      = bus.bus_req && bus.bus_ack;
    end

    // Sequencer FSM with registered bus and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_SETTLE;
            settle_cnt    <= '0;
            poll_cnt      <= '0;
            cfg_idx       <= 4'd0;
            vfy_idx       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 10'h000;
            bus.bus_wdata <= 16'h0000;
            busy          <= 1'b1;
            done          <= 1'b0;
            err_n         <= 1'b1;
        end else begin
            // A request launches only when bus_req is low, so the cycle after
            // each ack always leaves the mandatory one-cycle gap.
            if (xfer_state && !bus.bus_req) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= nxt_we;
                bus.bus_addr  <= nxt_addr;
                bus.bus_wdata <= nxt_wdata;
            end else if (acked) begin
                bus.bus_req <= 1'b0;
            end

            case (state)
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) state <= S_SRST;
                    else                           settle_cnt <= settle_cnt + 1'b1;
                end
                S_SRST: begin
                    if (acked) begin
                        poll_cnt <= '0;
                        state    <= S_POLL;
                    end
                end
                S_POLL: begin
                    if (acked) begin
                        if (!bus.bus_rdata[7]) begin
                            cfg_idx <= 4'd0;
                            state   <= S_CFG;
                        end else begin
                            poll_cnt <= poll_inc;
                            if (poll_inc == POLL_LAST) begin
                                state <= S_ERR;
                                busy  <= 1'b0;
                                done  <= 1'b0;
                                err_n <= 1'b0;
                            end
                        end
                    end
                end
                S_CFG: begin
                    if (acked) begin
                        if (cfg_idx == CFG_LAST) begin
                            vfy_idx <= 1'b0;
                            state   <= S_VERIFY;
                        end else begin
                            cfg_idx <= cfg_idx + 1'b1;
                        end
                    end
                end
                S_VERIFY: begin
                    if (acked) begin
                        if (bus.bus_rdata != vfy_exp) begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            done  <= 1'b0;
                            err_n <= 1'b0;
                        end else if (vfy_idx) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            err_n <= 1'b1;
                        end else begin
                            vfy_idx <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    // Re-run skips the settle phase: the chip is already powered.
                    if (start) begin
                        state <= S_SRST;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err_n <= 1'b1;
                    end
                end
                default: state <= S_SETTLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w5300_init_seq.sv
// Directed bench for w5300_init_seq with a 3-cycle-latency bus responder.
module tb_w5300_init_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, err_n;

    int checks = 0;
    int errors = 0;

    w5300_init_seq_if bus ();

    w5300_init_seq #(
        .SETTLE_CYCLES (16),
        .POLL_LIMIT    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done),
        .err_n (err_n)
    );

    always #5 clk = ~clk;

    // Responder controls (written by the main sequence only).
    int mr_busy = 0;      // number of MR reads returning 0x0080; negative = forever
    int mr_base = 0;
    bit corrupt = 1'b0;   // return 0xC0A9 on the 0x018 read

    // Responder state (written by the responder only).
    int          mr_seen = 0;
    int          n_xfer  = 0;
    int          wait_cnt = 0;
    int          stab_err = 0;
    logic        prev_req = 1'b0;
    logic        p_we;
    logic [9:0]  p_addr;
    logic [15:0] p_wdata;
    logic        log_we   [256];
    logic [9:0]  log_addr [256];
    logic [15:0] log_data [256];

    // Expected transfer list for one clean pass (hand-written).
    logic        e_we   [13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [9:0]  e_addr [13] = '{10'h000, 10'h000, 10'h008, 10'h00A, 10'h00C,
                                 10'h010, 10'h012, 10'h014, 10'h016, 10'h018,
                                 10'h01A, 10'h018, 10'h01A};
    logic [15:0] e_data [13] = '{16'h0080, 16'h0000, 16'h0008, 16'hDC01, 16'h0203,
                                 16'hC0A8, 16'h0001, 16'hFFFF, 16'hFF00, 16'hC0A8,
                                 16'h0064, 16'h0000, 16'h0000};

    // Bus responder: acks 3 cycles after request, also watches field stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.bus_ack   = 1'b0;
            bus.bus_rdata = 16'h0000;
            wait_cnt      = 0;
            prev_req      = 1'b0;
        end else begin
            if (bus.bus_req && prev_req &&
                (bus.bus_we !== p_we || bus.bus_addr !== p_addr || bus.bus_wdata !== p_wdata))
                stab_err++;
            prev_req = bus.bus_req;
            p_we     = bus.bus_we;
            p_addr   = bus.bus_addr;
            p_wdata  = bus.bus_wdata;
            if (bus.bus_ack) begin
                bus.bus_ack = 1'b0;
            end else if (bus.bus_req) begin
                wait_cnt++;
                if (wait_cnt == 3) begin
                    wait_cnt = 0;
                    bus.bus_rdata = 16'h0000;
                    if (!bus.bus_we) begin
                        case (bus.bus_addr)
                            10'h000: begin
                                if (mr_busy < 0 || (mr_seen - mr_base) < mr_busy)
                                    bus.bus_rdata = 16'h0080;
                                mr_seen++;
                            end
                            10'h018: bus.bus_rdata = corrupt ? 16'hC0A9 : 16'hC0A8;
                            10'h01A: bus.bus_rdata = 16'h0064;
                            default: bus.bus_rdata = 16'h0000;
                        endcase
                    end
                    bus.bus_ack = 1'b1;
                    if (n_xfer < 256) begin
                        log_we[n_xfer]   = bus.bus_we;
                        log_addr[n_xfer] = bus.bus_addr;
                        log_data[n_xfer] = bus.bus_we ? bus.bus_wdata : 16'h0000;
                    end
                    n_xfer++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (done !== 1'b1 && err_n !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 2000), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic int count_xfer(input int from, input int upto,
                                      input logic we, input logic [9:0] a);
        int c = 0;
        for (int i = from; i < upto && i < 256; i++)
            if (log_we[i] === we && log_addr[i] === a) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req",   32'(bus.bus_req),   32'd0);
        check("rst_we",    32'(bus.bus_we),    32'd0);
        check("rst_addr",  32'(bus.bus_addr),  32'd0);
        check("rst_wdata", 32'(bus.bus_wdata), 32'd0);
        check("rst_busy",  32'(busy),  32'd1);
        check("rst_done",  32'(done),  32'd0);
        check("rst_err_n", 32'(err_n), 32'd1);

        // Clean run: settle latency, first transfer, full transfer list
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.bus_req && n < 100);
        check("settle_latency", 32'(n), 32'd17);
        check("first_we",    32'(bus.bus_we),    32'd1);
        check("first_addr",  32'(bus.bus_addr),  32'h000);
        check("first_wdata", 32'(bus.bus_wdata), 32'h0080);
        wait_end("t1_timeout");
        check("t1_done",  32'(done),  32'd1);
        check("t1_busy",  32'(busy),  32'd0);
        check("t1_err_n", 32'(err_n), 32'd1);
        check("t1_nxfer", 32'(n_xfer), 32'd13);
        for (int i = 0; i < 13; i++) begin
            check($sformatf("t1_we[%0d]", i),   32'(log_we[i]),   32'(e_we[i]));
            check($sformatf("t1_addr[%0d]", i), 32'(log_addr[i]), 32'(e_addr[i]));
            check($sformatf("t1_data[%0d]", i), 32'(log_data[i]), 32'(e_data[i]));
        end

        // Restart from done, MR busy twice, stray start during configuration
        mr_base = mr_seen;
        mr_busy = 2;
        base = n_xfer;
        pulse_start();
        check("t2_done_drop", 32'(done), 32'd0);
        check("t2_busy",      32'(busy), 32'd1);
        n = 1;
        while (!bus.bus_req && n < 10) begin tick(); n++; end
        check("t2_restart_latency", 32'(n), 32'd2);
        check("t2_restart_we",   32'(bus.bus_we),    32'd1);
        check("t2_restart_addr", 32'(bus.bus_addr),  32'h000);
        n = 0;
        while (n_xfer < base + 5 && n < 500) begin tick(); n++; end
        check("t2_reach_cfg", 32'(n < 500), 32'd1);
        pulse_start();
        wait_end("t2_timeout");
        check("t2_done",     32'(done),  32'd1);
        check("t2_err_n",    32'(err_n), 32'd1);
        check("t2_nxfer",    32'(n_xfer - base), 32'd15);
        check("t2_mr_reads", 32'(count_xfer(base, n_xfer, 1'b0, 10'h000)), 32'd3);
        check("t2_mr_writes", 32'(count_xfer(base, n_xfer, 1'b1, 10'h000)), 32'd1);
        check("t2_shar_hi",  32'(log_data[base + 4]), 32'h0008);

        // Poll timeout: MR never clears
        mr_base = mr_seen;
        mr_busy = -1;
        base = n_xfer;
        pulse_start();
        wait_end("t3_timeout");
        check("t3_err_n", 32'(err_n), 32'd0);
        check("t3_done",  32'(done),  32'd0);
        check("t3_busy",  32'(busy),  32'd0);
        check("t3_mr_reads", 32'(count_xfer(base, n_xfer, 1'b0, 10'h000)), 32'd4);
        repeat (10) tick();
        check("t3_nxfer", 32'(n_xfer - base), 32'd5);
        check("t3_req_idle", 32'(bus.bus_req), 32'd0);

        // Readback mismatch on SIPR high word
        mr_base = mr_seen;
        mr_busy = 0;
        corrupt = 1'b1;
        base = n_xfer;
        pulse_start();
        check("t4_err_cleared", 32'(err_n), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(bus.bus_ack && !bus.bus_we && bus.bus_addr == 10'h018) && n < 500);
        check("t4_reach_verify", 32'(n < 500), 32'd1);
        check("t4_err_n_in_ack", 32'(err_n), 32'd1);
        @(posedge clk);
        #1;
        check("t4_err_n_after", 32'(err_n), 32'd0);
        check("t4_done",        32'(done),  32'd0);
        repeat (10) tick();
        check("t4_nxfer", 32'(n_xfer - base), 32'd12);
        check("t4_no_lo_read", 32'(count_xfer(base, n_xfer, 1'b0, 10'h01A)), 32'd0);
        corrupt = 1'b0;

        // Reset while a transfer is outstanding
        base = n_xfer;
        pulse_start();
        n = 0;
        while (!(n_xfer >= base + 4 && bus.bus_req) && n < 500) begin tick(); n++; end
        check("t5_mid_xfer", 32'(bus.bus_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_req_async", 32'(bus.bus_req), 32'd0);
        check("t5_busy",      32'(busy),  32'd1);
        check("t5_done",      32'(done),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.bus_req && n < 100);
        check("t5_settle_latency", 32'(n), 32'd17);
        wait_end("t5_timeout");
        check("t5_done_final", 32'(done),  32'd1);
        check("t5_err_n",      32'(err_n), 32'd1);

        check("bus_fields_stable", 32'(stab_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
